// File: rtl/platform_btn_pkg.sv
// Shared constants, grant type and round-robin search for the push-button
// interrupt controller.
package platform_btn_pkg;

    localparam logic [1:0] ADDR_DATA  = 2'd0;
    localparam logic [1:0] ADDR_EVENT = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    localparam int EVT_VALID_BIT = 31;

    typedef struct packed {
        logic       valid;
        logic [4:0] idx;
    } rr_grant_t;

    // Scans downwards so the last hit written is the one closest to ptr.
    function automatic rr_grant_t rr_search(input logic [31:0] req,
                                            input logic [4:0]  ptr,
                                            input int          n);
        rr_grant_t  g;
        logic [5:0] idx;
        g = '0;
        for (int k = 31; k >= 0; k--) begin
            if (k < n) begin
                idx = {1'b0, ptr} + 6'(k);
                if (idx >= 6'(n)) idx = idx - 6'(n);
                if (req[idx[4:0]]) begin
                    g.valid = 1'b1;
                    g.idx   = idx[4:0];
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/platform_btn_debounce.sv
// Single-bit 2-FF synchroniser plus optional debouncer.
// Debounce counter is built only when PLATFORM_BTN_DEBOUNCE_EN is defined.
module platform_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_i,
    output logic deb_o
);
    logic s1_q, s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

`ifdef PLATFORM_BTN_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (s2_q != deb_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) deb_d = s2_q;
            else                                   cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign deb_o = deb_q;
`else
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

    // Without debouncing the second synchroniser stage is the level.
    assign deb_o = s2_q;
`endif

endmodule

// File: rtl/platform_button_irq_ctrl.sv
// Push-button interrupt controller: edge capture, mask, round-robin event
// register on Avalon-MM. Debouncing enabled by PLATFORM_BTN_DEBOUNCE_EN.
module platform_button_irq_ctrl
    import platform_btn_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_BUTTONS-1:0] in_port,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 read_n,
    input  logic                 write_n,
    input  logic [31:0]          writedata,
    output logic [31:0]          readdata,
    output logic                 irq
);
    logic [N_BUTTONS-1:0] deb, deb_prev_q, rise, pend;
    logic [N_BUTTONS-1:0] edge_q, edge_d, mask_q, mask_d;
    logic [4:0]           ptr_q, ptr_d;
    logic [31:0]          rdata_q, rdata_d, clr;
    logic                 rd_stb, wr_stb;
    rr_grant_t            grant;
    logic                 unused_wdata;

    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
        platform_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .raw_i  (in_port[gi]),
            .deb_o  (deb[gi])
        );
    end

    assign unused_wdata = ^writedata;
    assign rd_stb = chipselect & ~read_n;
    assign wr_stb = chipselect & ~write_n;
    assign rise   = deb & ~deb_prev_q;
    assign pend   = edge_q & mask_q;
    assign grant  = rr_search(32'(pend), ptr_q, N_BUTTONS);
    assign irq    = |pend;

    always_comb begin
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        clr     = '0;
        if (wr_stb) begin
            case (address)
                ADDR_MASK: mask_d = writedata[N_BUTTONS-1:0];
                ADDR_EDGE: clr    = writedata;
                default:   ;
            endcase
        end
        if (rd_stb) begin
            case (address)
                ADDR_DATA:  rdata_d = 32'(deb);
                ADDR_EVENT: begin
                    rdata_d                = '0;
                    rdata_d[EVT_VALID_BIT] = grant.valid;
                    rdata_d[4:0]           = grant.idx;
                    if (grant.valid) begin
                        clr[grant.idx] = 1'b1;
                        ptr_d = (grant.idx == 5'(N_BUTTONS - 1)) ? 5'd0 : grant.idx + 5'd1;
                    end
                end
                ADDR_MASK:  rdata_d = 32'(mask_q);
                default:    rdata_d = 32'(edge_q);
            endcase
        end
        // A capture in the same cycle as a clear keeps the bit set.
        edge_d = (edge_q & ~clr[N_BUTTONS-1:0]) | rise;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q <= '0;
            edge_q     <= '0;
            mask_q     <= '0;
            ptr_q      <= '0;
            rdata_q    <= '0;
        end else begin
            deb_prev_q <= deb;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
            rdata_q    <= rdata_d;
        end
    end

    assign readdata = rdata_q;

endmodule

// File: tb/tb_platform_button_irq_ctrl.sv
// Scoreboard bench for platform_button_irq_ctrl (N_BUTTONS=4, DEBOUNCE_CYCLES=4).
module tb_platform_button_irq_ctrl;
    localparam int N  = 4;
    localparam int DC = 4;
`ifdef PLATFORM_BTN_DEBOUNCE_EN
    localparam int LAT = 2 + DC + 1;
`else
    localparam int LAT = 3;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  in_port = '0;
    logic [1:0]    address = '0;
    logic          chipselect = 1'b0;
    logic          read_n = 1'b1;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = '0;
    logic [31:0]   readdata;
    logic          irq;

    platform_button_irq_ctrl #(.N_BUTTONS(N), .DEBOUNCE_CYCLES(DC)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_port   (in_port),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];
    logic        irq_exp_q[$];
    string       irq_name_q[$];
    int          total = 0;
    int          bad = 0;
    logic        rd_seen = 1'b0;
    logic        rd_probe = 1'b0;
    logic        irq_probe = 1'b0;
    logic [31:0] mon_exp;
    logic        mon_irq_exp;
    string       mon_name;

    always @(posedge clk) rd_seen <= chipselect && !read_n;

    // Monitor: pops an expectation whenever the DUT presents read data or irq is probed.
    always @(negedge clk) begin
        if (rd_seen || rd_probe) begin
            total++;
            if (rd_exp_q.size() == 0) begin
                bad++;
                $display("FAIL rd_unexpected: readdata=%h with no expectation queued", readdata);
            end else begin
                mon_exp  = rd_exp_q.pop_front();
                mon_name = rd_name_q.pop_front();
                if (readdata !== mon_exp) begin
                    bad++;
                    $display("FAIL %s: readdata=%h expected=%h", mon_name, readdata, mon_exp);
                end
            end
        end
        if (irq_probe) begin
            total++;
            if (irq_exp_q.size() == 0) begin
                bad++;
                $display("FAIL irq_unexpected: irq=%b with no expectation queued", irq);
            end else begin
                mon_irq_exp = irq_exp_q.pop_front();
                mon_name    = irq_name_q.pop_front();
                if (irq !== mon_irq_exp) begin
                    bad++;
                    $display("FAIL %s: irq=%b expected=%b", mon_name, irq, mon_irq_exp);
                end
            end
        end
    end

    // All tasks start and end 1 time unit after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input string nm);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(nm);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        tick(1);
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic chk_irq(input logic exp, input string nm);
        irq_exp_q.push_back(exp);
        irq_name_q.push_back(nm);
        irq_probe = 1'b1;
        @(negedge clk);
        #1;
        irq_probe = 1'b0;
        tick(1);
    endtask

    task automatic chk_rd_now(input logic [31:0] exp, input string nm);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(nm);
        rd_probe = 1'b1;
        @(negedge clk);
        #1;
        rd_probe = 1'b0;
        tick(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            in_port = 4'(4'hF >> i);
            tick(1);
        end
        chk_rd_now(32'h0, "rst_readdata");
        chk_irq(1'b0, "rst_irq");
        in_port = '0;
        tick(2);
        reset_n = 1'b1;
        tick(3);
        rd(2'd0, 32'h0, "rst_data");
        rd(2'd1, 32'h0, "rst_event");
        rd(2'd2, 32'h0, "rst_mask");
        rd(2'd3, 32'h0, "rst_edge");

`ifdef PLATFORM_BTN_DEBOUNCE_EN
        // Short glitch is filtered
        in_port = 4'h2;
        tick(3);
        in_port = 4'h0;
        tick(12);
        rd(2'd3, 32'h0, "glitch_edge");
        rd(2'd0, 32'h0, "glitch_level");
`else
        // One-clock pulse captured three clocks later
        in_port = 4'h8;
        tick(1);
        in_port = 4'h0;
        tick(1);
        rd(2'd3, 32'h0, "pulse_before");
        rd(2'd3, 32'h8, "pulse_capture");
        wr(2'd3, 32'h8);
        rd(2'd3, 32'h0, "pulse_w1c");
`endif

        // Held press: capture exactly LAT clocks after the rise
        in_port = 4'h2;
        tick(LAT - 1);
        rd(2'd3, 32'h0, "press_before");
        rd(2'd3, 32'h2, "press_capture");
        rd(2'd0, 32'h2, "press_level");
        tick(10 - LAT - 2);
        in_port = 4'h0;
        tick(LAT + 3);
        rd(2'd3, 32'h2, "release_ignored");

        // Mask and irq
        chk_irq(1'b0, "irq_masked");
        wr(2'd2, 32'h2);
        chk_irq(1'b1, "irq_unmasked");
        rd(2'd2, 32'h2, "mask_readback");
        wr(2'd3, 32'h2);
        chk_irq(1'b0, "irq_after_w1c");
        rd(2'd3, 32'h0, "edge_after_w1c");

        // Round-robin over buttons 0, 2, 3
        wr(2'd2, 32'hF);
        in_port = 4'b1101;
        tick(LAT + 2);
        in_port = 4'h0;
        tick(LAT + 3);
        rd(2'd3, 32'hD, "rr_edges");
        chk_irq(1'b1, "rr_irq");
        rd(2'd1, 32'h8000_0000, "rr_pop0");
        rd(2'd1, 32'h8000_0002, "rr_pop2");
        rd(2'd1, 32'h8000_0003, "rr_pop3");
        rd(2'd1, 32'h0000_0000, "rr_empty");
        chk_irq(1'b0, "rr_irq_clear");
        in_port = 4'h1;
        tick(LAT + 2);
        in_port = 4'h0;
        tick(LAT + 3);
        rd(2'd1, 32'h8000_0000, "rr_again0");
        rd(2'd3, 32'h0, "rr_edges_clear");

        // Masked bit captures but is not granted
        wr(2'd2, 32'h8);
        in_port = 4'h2;
        tick(LAT + 2);
        in_port = 4'h0;
        tick(LAT + 3);
        rd(2'd3, 32'h2, "masked_capture");
        chk_irq(1'b0, "masked_irq");
        rd(2'd1, 32'h0, "masked_no_grant");
        wr(2'd2, 32'hF);
        chk_irq(1'b1, "unmask_irq");
        rd(2'd1, 32'h8000_0001, "unmask_grant1");

        // W1C collides with capture of button 2
        in_port = 4'h4;
        tick(LAT - 1);
        wr(2'd3, 32'h4);
        chk_irq(1'b1, "collide_irq");
        rd(2'd3, 32'h4, "collide_edge");
        in_port = 4'h0;
        tick(LAT + 3);
        wr(2'd3, 32'h4);
        chk_irq(1'b0, "final_irq");

        tick(3);
        if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending rd=%0d irq=%0d expected 0", rd_exp_q.size(), irq_exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
